// File: rtl/axi4_lite_wr_slave_ctrl.sv
// AXI4-Lite write-only slave: joins the AW and W channels, issues one memory write strobe and
// returns a B response. Only one transaction is in flight at a time.
module axi4_lite_wr_slave_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 4096
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [ADDR_WIDTH-1:0]        AWADDR,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [DATA_WIDTH-1:0]        WDATA,
   input  logic [DATA_WIDTH/8-1:0]      WSTRB,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   output logic                         mem_we,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]        mem_wdata,
   output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);

   localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
   localparam int unsigned WordW = ADDR_WIDTH - 2;
   localparam int unsigned StrbW = DATA_WIDTH / 8;
   localparam logic [WordW-1:0] DepthWord = WordW'(MEM_DEPTH);
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StAddrHeld,
      StDataHeld,
      StWrite,
      StResp
   } state_e;

   state_e                 state_q, state_d;
   logic [WordW-1:0]       word_q, word_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [StrbW-1:0]       wstrb_q, wstrb_d;
   logic [1:0]             bresp_q, bresp_d;
   logic                   awready_q, awready_d;
   logic                   wready_q, wready_d;
   logic                   bvalid_q, bvalid_d;
   logic                   mem_we_q, mem_we_d;
   logic                   aw_hs, w_hs;
   logic                   unused_addr_lsbs;

   // Byte offset within a word never affects the word index.
   assign unused_addr_lsbs = ^AWADDR[1:0];

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      // Ready flags are low in WRITE/RESP, so handshakes there cannot occur.
      aw_hs     = AWVALID && awready_q;
      w_hs      = WVALID && wready_q;

      if (aw_hs) begin
         word_d = AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         wdata_d = WDATA;
         wstrb_d = WSTRB;
      end

      unique case (state_q)
         StIdle: begin
            if (aw_hs && w_hs) begin
               state_d = StWrite;
            end else if (aw_hs) begin
               state_d = StAddrHeld;
            end else if (w_hs) begin
               state_d = StDataHeld;
            end
         end
         StAddrHeld: begin
            if (w_hs) begin
               state_d = StWrite;
            end
         end
         StDataHeld: begin
            if (aw_hs) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            state_d = StResp;
            bresp_d = (word_q < DepthWord) ? RespOkay : RespSlverr;
         end
         StResp: begin
            if (bvalid_q && BREADY) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered: derive them from the state being entered.
      awready_d = (state_d == StIdle) || (state_d == StDataHeld);
      wready_d  = (state_d == StIdle) || (state_d == StAddrHeld);
      bvalid_d  = (state_d == StResp);
      mem_we_d  = (state_d == StWrite) && (word_d < DepthWord);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= StIdle;
         word_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RespOkay;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         mem_we_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         mem_we_q  <= mem_we_d;
      end
   end

   assign AWREADY   = awready_q;
   assign WREADY    = wready_q;
   assign BVALID    = bvalid_q;
   assign BRESP     = bresp_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = word_q[IdxW-1:0];
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_axi4_lite_wr_slave_ctrl.sv
// Scoreboard bench: stimulus pushes expected memory writes and B responses; a negedge monitor
// pops and compares whenever the DUT strobes mem_we or completes a B handshake.
module tb_axi4_lite_wr_slave_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int n_cmp = 0;
   int n_err = 0;

   logic [47:0] mem_q[$];
   logic [1:0]  b_q[$];

   axi4_lite_wr_slave_ctrl #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_DEPTH (4096)
   ) dut (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .AWADDR   (AWADDR),
      .AWVALID  (AWVALID),
      .AWREADY  (AWREADY),
      .WDATA    (WDATA),
      .WSTRB    (WSTRB),
      .WVALID   (WVALID),
      .WREADY   (WREADY),
      .BRESP    (BRESP),
      .BVALID   (BVALID),
      .BREADY   (BREADY),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every DUT output event must match the head of its queue.
   always @(negedge ACLK) begin
      if (mem_we === 1'b1) begin
         if (mem_q.size() == 0) begin
            chk("unexpected_mem_we", {mem_addr, mem_wdata, mem_wstrb}, 64'hffff_ffff_ffff_ffff);
         end else begin
            chk("mem_write", {mem_addr, mem_wdata, mem_wstrb}, mem_q.pop_front());
         end
      end
      if (BVALID === 1'b1 && BREADY === 1'b1) begin
         if (b_q.size() == 0) begin
            chk("unexpected_bresp", {62'd0, BRESP}, 64'hffff_ffff_ffff_ffff);
         end else begin
            chk("bresp", {62'd0, BRESP}, {62'd0, b_q.pop_front()});
         end
      end
   end

   task automatic cyc();
      @(posedge ACLK);
      #1;
   endtask

   // Counts edges from now until BVALID is seen; bounded.
   task automatic wait_bvalid(output int edges);
      edges = 0;
      while (BVALID !== 1'b1 && edges < 20) begin
         cyc();
         edges++;
      end
   endtask

   task automatic drive_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      AWADDR  = a;
      WDATA   = d;
      WSTRB   = s;
      AWVALID = 1'b1;
      WVALID  = 1'b1;
   endtask

   task automatic drop_valids();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      ARESETN = 1'b0;
      AWADDR  = '0;
      AWVALID = 1'b0;
      WDATA   = '0;
      WSTRB   = '0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;
      #1;
      chk("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, mem_we}, 6'b000000);
      cyc();
      cyc();
      ARESETN = 1'b1;
      #1;
      chk("ready_low_before_edge", {AWREADY, WREADY}, 2'b00);
      cyc();
      chk("ready_after_reset", {AWREADY, WREADY}, 2'b11);

      // AW and W in the same cycle; address low bits ignored.
      mem_q.push_back({12'h2a6, 32'h1a2b3c4d, 4'hf});
      b_q.push_back(2'b00);
      drive_both(32'ha9b, 32'h1a2b3c4d, 4'hf);
      cyc();
      drop_valids();
      chk("t1_in_write", {AWREADY, WREADY, mem_we}, 3'b001);
      wait_bvalid(lat);
      chk("t1_latency", 64'(lat + 1), 64'd2);
      cyc();
      chk("t1_back_idle", {BVALID, AWREADY, WREADY, mem_we}, 4'b0110);

      // W first, AW three cycles later.
      mem_q.push_back({12'h004, 32'hdeadbeef, 4'b0101});
      b_q.push_back(2'b00);
      WDATA  = 32'hdeadbeef;
      WSTRB  = 4'b0101;
      WVALID = 1'b1;
      cyc();
      WVALID = 1'b0;
      WDATA  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_data_held", {AWREADY, WREADY, mem_we, BVALID}, 4'b1000);
         cyc();
      end
      AWADDR  = 32'h10;
      AWVALID = 1'b1;
      wait_bvalid(lat);
      AWVALID = 1'b0;
      chk("t2_latency", 64'(lat), 64'd2);
      cyc();

      // Out of range: word index 4096 -> SLVERR, no memory write.
      b_q.push_back(2'b10);
      drive_both(32'h4000, 32'h55aa55aa, 4'hf);
      cyc();
      drop_valids();
      chk("t3_no_we", {62'd0, mem_we}, 64'd0);
      wait_bvalid(lat);
      chk("t3_latency", 64'(lat + 1), 64'd2);
      cyc();

      // Last in-range word.
      mem_q.push_back({12'hfff, 32'h0badf00d, 4'b1000});
      b_q.push_back(2'b00);
      drive_both(32'h3ffc, 32'h0badf00d, 4'b1000);
      cyc();
      drop_valids();
      wait_bvalid(lat);
      chk("t4_latency", 64'(lat + 1), 64'd2);
      cyc();

      // BREADY low for 5 cycles while BVALID is up.
      BREADY = 1'b0;
      mem_q.push_back({12'h002, 32'h12345678, 4'b0011});
      b_q.push_back(2'b00);
      drive_both(32'h8, 32'h12345678, 4'b0011);
      cyc();
      drop_valids();
      AWVALID = 1'b1;
      AWADDR  = 32'h100;
      wait_bvalid(lat);
      for (int i = 0; i < 5; i++) begin
         chk("t5_resp_hold", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
         cyc();
      end
      AWVALID = 1'b0;
      BREADY  = 1'b1;
      cyc();
      chk("t5_idle_after_bready", {BVALID, AWREADY, WREADY}, 3'b011);

      // Reset while in RESP: BVALID drops asynchronously and never returns.
      BREADY = 1'b0;
      mem_q.push_back({12'h008, 32'hcafef00d, 4'hf});
      drive_both(32'h20, 32'hcafef00d, 4'hf);
      cyc();
      drop_valids();
      wait_bvalid(lat);
      chk("t6_in_resp", {63'd0, BVALID}, 64'd1);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("t6_async_clear", {BVALID, AWREADY, WREADY}, 3'b000);
      @(negedge ACLK);
      ARESETN = 1'b1;
      BREADY  = 1'b1;
      cyc();
      chk("t6_ready_after_reset", {AWREADY, WREADY}, 2'b11);
      for (int i = 0; i < 4; i++) begin
         chk("t6_no_x", {62'd0, $isunknown({BVALID, AWREADY, WREADY}), BVALID}, 64'd0);
         cyc();
      end

      // Reset while holding only an address: that transaction must vanish.
      AWADDR  = 32'h40;
      AWVALID = 1'b1;
      cyc();
      AWVALID = 1'b0;
      chk("t7_addr_held", {AWREADY, WREADY}, 2'b01);
      ARESETN = 1'b0;
      #2;
      ARESETN = 1'b1;
      WDATA   = 32'h77777777;
      WVALID  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t7_abandoned", {BVALID, mem_we}, 2'b00);
      end

      cyc();
      chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
      chk("b_queue_drained", 64'(b_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_lite_wr_slave_ctrl.md
AXI4_LITE_WR_SLAVE_CTRL -- requirements
Module: axi4_lite_wr_slave_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits (32 only).
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, number of DATA_WIDTH words in the target memory.
REQ-004 SHALL have port ACLK  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port ARESETN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port AWADDR  input  ADDR_WIDTH  write address, byte address.
REQ-007 SHALL have port AWVALID  input  1  write address valid.
REQ-008 SHALL have port AWREADY  output  1  write address accepted.
REQ-009 SHALL have port WDATA  input  DATA_WIDTH  write data.
REQ-010 SHALL have port WSTRB  input  DATA_WIDTH/8  byte-lane strobes.
REQ-011 SHALL have port WVALID  input  1  write data valid.
REQ-012 SHALL have port WREADY  output  1  write data accepted.
REQ-013 SHALL have port BRESP  output  2  write response, 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 SHALL have port BVALID  output  1  write response valid.
REQ-015 SHALL have port BREADY  input  1  master accepts response.
REQ-016 SHALL have port mem_we  output  1  single-cycle memory write strobe.
REQ-017 SHALL have port mem_addr  output  $clog2(MEM_DEPTH)  word index, AWADDR>>2.
REQ-018 SHALL have port mem_wdata  output  DATA_WIDTH  captured WDATA.
REQ-019 SHALL have port mem_wstrb  output  DATA_WIDTH/8  captured WSTRB.

Function
REQ-020 SHALL implement states IDLE, ADDR_HELD, DATA_HELD, WRITE, RESP.
REQ-021 SHALL drive AWREADY=1 in IDLE and DATA_HELD only, and WREADY=1 in IDLE and ADDR_HELD only, both registered outputs.
REQ-022 SHALL capture AWADDR on an AW handshake (AWVALID&&AWREADY) and WDATA/WSTRB on a W handshake (WVALID&&WREADY).
REQ-023 SHALL transition IDLE->ADDR_HELD on AW only, IDLE->DATA_HELD on W only, IDLE->WRITE on both in the same cycle.
REQ-024 SHALL transition ADDR_HELD->WRITE on W handshake and DATA_HELD->WRITE on AW handshake; otherwise hold state indefinitely.
REQ-025 SHALL in WRITE assert mem_we for exactly one cycle when captured word index < MEM_DEPTH, with mem_addr/mem_wdata/mem_wstrb stable that cycle, then go to RESP.
REQ-026 SHALL in WRITE suppress mem_we when word index >= MEM_DEPTH and set BRESP=2'b10; otherwise BRESP=2'b00.
REQ-027 SHALL assert BVALID throughout RESP; BRESP stable while BVALID=1; BVALID not deasserted until BREADY=1.
REQ-028 SHALL on BVALID&&BREADY return to IDLE and drop BVALID next cycle; BREADY high before BVALID costs no extra cycle.
REQ-029 SHALL give latency of 2 cycles from the cycle both handshakes are complete to BVALID=1 (WRITE then RESP).
REQ-030 SHALL ignore AWVALID/WVALID while in WRITE or RESP (no capture, ready low); one outstanding transaction max.
REQ-031 SHALL ignore AWADDR[1:0] for word indexing.

Reset
REQ-032 SHALL on ARESETN=0 immediately force state IDLE, AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00, mem_we=0, captured registers 0.
REQ-033 SHALL raise AWREADY and WREADY on the first ACLK posedge after ARESETN deasserts.
REQ-034 SHALL abandon any in-flight transaction on reset mid-operation, with no mem_we and no BVALID afterward for it.

Verification
REQ-035 SHALL cover: AW 32'ha9b + W 32'h1a2b3c4d, WSTRB 4'hf same cycle -> mem_we one cycle, mem_addr 'h2a6, BVALID 2 cycles later, BRESP 00.
REQ-036 SHALL cover: W first, AW 3 cycles later -> WREADY low after W capture, AWREADY held high, single mem_we after AW, BRESP 00.
REQ-037 SHALL cover: AWADDR 32'h4000 (index 4096) -> no mem_we, BVALID with BRESP 2'b10.
REQ-038 SHALL cover: BREADY held low 5 cycles -> BVALID and BRESP stable 5 cycles, AWREADY/WREADY low, IDLE one cycle after BREADY.
REQ-039 SHALL cover: ARESETN low while in RESP -> BVALID 0 asynchronously, no X on BVALID/AWREADY/WREADY while ARESETN=1.
